// File: rtl/fp_dlfloat_pkg.sv
// Shared DLFloat16 definitions: field widths, exception bit positions, operand
// classes and the stage-1 pipeline record used by the float-to-int converter.
package fp_dlfloat_pkg;

  localparam int EXP_W = 6;
  localparam int MAN_W = 9;
  localparam int BIAS  = 31;
  localparam int INT_W = 32;
  localparam int EXC_W = 5;

  localparam int EXC_NV = 4;
  localparam int EXC_OF = 3;
  localparam int EXC_FL = 2;
  localparam int EXC_NX = 1;

  localparam logic [EXP_W-1:0] EXP_MAX   = '1;
  localparam logic [MAN_W-1:0] MAN_MAX   = '1;
  localparam logic [INT_W-1:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [INT_W-1:0] INT32_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SPECIAL,
    CLS_TINY,
    CLS_OVF,
    CLS_NORM
  } f2i_class_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] mant;
  } dlf16_t;

  typedef struct packed {
    f2i_class_e     cls;
    logic           sign;
    logic           shl;    // 1: shift significand left, 0: shift right
    logic [4:0]     shamt;
    logic [MAN_W:0] sig;    // {hidden 1, mantissa}
    logic           flush;
  } f2i_s1_t;

endpackage

// File: rtl/fp_f2i_shift_round.sv
// Stage-2 datapath: aligns the significand, derives guard/sticky, rounds, applies
// sign and saturation. Round-to-nearest-even is enabled by FP_F2I_RNE_EN.
module fp_f2i_shift_round
  import fp_dlfloat_pkg::*;
(
  input  f2i_s1_t           s1_i,
  output logic [INT_W-1:0]  res_o,
  output logic [EXC_W-1:0]  exc_o
);

  logic [19:0]      ext;
  logic             guard;
  logic             sticky;
  logic [INT_W-1:0] mag;
  logic [INT_W-1:0] mag_r;
  logic [INT_W-1:0] mag_s;

  // TINY operands arrive with shamt 10/11 so the right-shift path yields
  // magnitude 0 with the correct guard/sticky for the e == -1 rounding case.
  always_comb begin
    ext    = {s1_i.sig, 10'b0} >> s1_i.shamt;
    guard  = ext[9];
    sticky = |ext[8:0];
    mag    = s1_i.shl ? (INT_W'(s1_i.sig) << s1_i.shamt) : INT_W'(ext[19:10]);
`ifdef FP_F2I_RNE_EN
    mag_r  = mag + INT_W'(!s1_i.shl && guard && (sticky || mag[0]));
`else
    mag_r  = mag;
`endif
    mag_s  = s1_i.sign ? -mag_r : mag_r;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    res_o = '0;
    exc_o = '0;
    case (s1_i.cls)
      CLS_ZERO: exc_o[EXC_FL] = s1_i.flush;
      CLS_SPECIAL: begin
        res_o         = INT32_MAX;
        exc_o[EXC_NV] = 1'b1;
      end
      CLS_OVF: begin
        res_o         = s1_i.sign ? INT32_MIN : INT32_MAX;
        exc_o[EXC_OF] = 1'b1;
      end
      default: begin
        res_o         = mag_s;
        exc_o[EXC_NX] = !s1_i.shl && (guard || sticky);
`ifdef FP_F2I_RNE_EN
        if (!s1_i.sign && mag_r[INT_W-1]) begin
          res_o         = INT32_MAX;
          exc_o[EXC_OF] = 1'b1;
          exc_o[EXC_NX] = 1'b0;
        end
`endif
      end
    endcase
  end

endmodule

// File: rtl/fp_float2int.sv
// DLFloat16 to int32 converter, 2-stage valid/ready pipeline (decode, then
// shift/round/saturate). Optional round-to-nearest-even via FP_F2I_RNE_EN.
module fp_float2int
  import fp_dlfloat_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_float,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INT_W-1:0]  out_int,
  output logic [EXC_W-1:0]  exceptions
);

  dlf16_t            op;
  logic signed [6:0] e_s;
  f2i_s1_t           s1_d, s1_q;
  logic              s1_valid_d, s1_valid_q;
  logic              init_q;
  logic              out_valid_q;
  logic [INT_W-1:0]  out_int_q, res;
  logic [EXC_W-1:0]  exc_q, exc;
  logic              out_free, s1_advance, in_fire;

  assign op  = dlf16_t'(in_float);
  assign e_s = $signed({1'b0, op.exp} - 7'(BIAS));

  always_comb begin
    s1_d       = '0;
    s1_d.sign  = op.sign;
    s1_d.sig   = {1'b1, op.mant};
    if (op.exp == '0) begin
      s1_d.cls   = CLS_ZERO;
      s1_d.flush = |op.mant;
    end else if (op.exp == EXP_MAX && op.mant == MAN_MAX) begin
      s1_d.cls = CLS_SPECIAL;
    end else if (e_s < 0) begin
      s1_d.cls   = CLS_TINY;
      s1_d.shamt = (e_s == -7'sd1) ? 5'd10 : 5'd11;
    end else if (e_s >= 7'sd32 || (e_s == 7'sd31 && !(op.sign && op.mant == '0))) begin
      s1_d.cls = CLS_OVF;
    end else begin
      s1_d.cls = CLS_NORM;
      if (e_s >= 7'sd9) begin
        s1_d.shl   = 1'b1;
        s1_d.shamt = e_s[4:0] - 5'd9;
      end else begin
        s1_d.shamt = 5'd9 - e_s[4:0];
      end
    end
  end

  assign out_free   = !out_valid_q || out_ready;
  assign s1_advance = s1_valid_q && out_free;
  assign in_ready   = init_q && (!s1_valid_q || s1_advance);
  assign in_fire    = in_valid && in_ready;
  assign s1_valid_d = in_fire || (s1_valid_q && !s1_advance);

  fp_f2i_shift_round u_shift_round (
    .s1_i  (s1_q),
    .res_o (res),
    .exc_o (exc)
  );

  // NOTE: data registers are reset too, because the result and flags must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_int_q   <= '0;
      exc_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      init_q     <= 1'b1;
      s1_valid_q <= s1_valid_d;
      if (in_fire) s1_q <= s1_d;
      if (out_free) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_int_q <= res;
          exc_q     <= exc;
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_int    = out_int_q;
  assign exceptions = exc_q;

endmodule

// File: tb/tb_fp_float2int.sv
// Directed self-checking bench for fp_float2int; expectations follow the
// FP_F2I_RNE_EN setting of the build.
module tb_fp_float2int;

`ifdef FP_F2I_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  localparam logic [4:0] F_NONE = 5'h00;
  localparam logic [4:0] F_NX   = 5'h02;
  localparam logic [4:0] F_FL   = 5'h04;
  localparam logic [4:0] F_OF   = 5'h08;
  localparam logic [4:0] F_NV   = 5'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_float = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_int;
  logic [4:0]  exceptions;

  int checks = 0;
  int errors = 0;

  logic [15:0] sv_f [8] = '{16'h3E00, 16'hBE00, 16'h4080, 16'h7BFF,
                            16'hFC00, 16'h7FFF, 16'h0001, 16'h4200};
  logic [31:0] sv_i [8] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0002, 32'h7FE0_0000,
                            32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0004};
  logic [4:0]  sv_x [8] = '{F_NONE, F_NONE, F_NX, F_NONE, F_NONE, F_NV, F_FL, F_NONE};

  fp_float2int dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_float   (in_float),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_int    (out_int),
    .exceptions (exceptions)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // The accepting edge counts as the first of the two latency cycles.
  task automatic convert(input logic [15:0] f, input logic [31:0] exp_int,
                         input logic [4:0] exp_exc, input string tag);
    int lat;
    @(negedge clk);
    in_float  = f;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd2);
    check({tag, " int"}, out_int, exp_int);
    check({tag, " exc"}, 32'(exceptions), 32'(exp_exc));
  endtask

  initial begin
    int          sent, rcv, cyc, occ;
    logic        stalled, saw_full;
    logic [31:0] hold_int;
    logic [4:0]  hold_exc;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_int", out_int, 32'd0);
    check("rst exc", 32'(exceptions), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst in_ready", 32'(in_ready), 32'd1);

    // Directed conversions
    convert(16'h3E00, 32'h0000_0001, F_NONE, "1.0");
    convert(16'hBE00, 32'hFFFF_FFFF, F_NONE, "-1.0");
    convert(16'h4080, 32'h0000_0002, F_NX,   "2.5");
    convert(16'h4180, RNE ? 32'd4 : 32'd3, F_NX, "3.5");
    convert(16'h7E00, 32'h7FFF_FFFF, F_OF,   "2^32");
    convert(16'hFC00, 32'h8000_0000, F_NONE, "-2^31");
    convert(16'hFE00, 32'h8000_0000, F_OF,   "-2^32");
    convert(16'h7C00, 32'h7FFF_FFFF, F_OF,   "2^31");
    convert(16'hFC01, 32'h8000_0000, F_OF,   "-2^31 ovf");
    convert(16'h7FFF, 32'h7FFF_FFFF, F_NV,   "+special");
    convert(16'hFFFF, 32'h7FFF_FFFF, F_NV,   "-special");
    convert(16'h0000, 32'h0000_0000, F_NONE, "zero");
    convert(16'h0001, 32'h0000_0000, F_FL,   "flush");
    convert(16'h7BFF, 32'h7FE0_0000, F_NONE, "max norm");
    convert(16'h4200, 32'h0000_0004, F_NONE, "4.0");
    convert(16'h3800, 32'h0000_0000, F_NX,   "0.125");
    convert(16'h3C00, 32'h0000_0000, F_NX,   "0.5");
    convert(16'h3C01, RNE ? 32'd1 : 32'd0, F_NX, ">0.5");
    convert(16'hBC01, RNE ? 32'hFFFF_FFFF : 32'd0, F_NX, "<-0.5");

    // Stream with out_ready toggling 1010... and random in_valid
    sent = 0; rcv = 0; cyc = 0;
    stalled = 1'b0; saw_full = 1'b0;
    hold_int = '0; hold_exc = '0;
    while (rcv < 8 && cyc < 200) begin
      @(negedge clk);
      if (stalled) begin
        check("stall valid", 32'(out_valid), 32'd1);
        check("stall int", out_int, hold_int);
        check("stall exc", 32'(exceptions), 32'(hold_exc));
      end
      out_ready = (cyc % 2 == 0);
      in_valid  = (sent < 8) && (cyc < 4 || $urandom_range(0, 1) == 1);
      in_float  = sv_f[(sent < 8) ? sent : 0];
      #1;
      occ = sent - rcv;
      check("stream in_ready", 32'(in_ready), 32'((occ < 2) || out_ready));
      if (occ == 2 && !out_ready) saw_full = 1'b1;
      if (out_valid && out_ready) begin
        check("stream int", out_int, sv_i[rcv]);
        check("stream exc", 32'(exceptions), 32'(sv_x[rcv]));
        rcv++;
      end
      stalled  = out_valid && !out_ready;
      hold_int = out_int;
      hold_exc = exceptions;
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    check("stream received", 32'(rcv), 32'd8);
    check("stream both full", 32'(saw_full), 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("stream no duplicate", 32'(out_valid), 32'd0);

    // Reset with two operands in flight
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_float  = 16'h3E00;
    @(negedge clk);
    in_float  = 16'h4200;
    @(negedge clk);
    in_valid  = 1'b0;
    check("inflight valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst valid", 32'(out_valid), 32'd0);
    check("async rst int", out_int, 32'd0);
    check("async rst exc", 32'(exceptions), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no stale result", 32'(out_valid), 32'd0);
    end
    convert(16'h4200, 32'h0000_0004, F_NONE, "post-reset 4.0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
